// File: rtl/eval_seq_pkg.sv
// Shared types and constants for the settle sequencer.
// Holds the FSM state encoding, the model code widths and the abs-diff helper.
package eval_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MRST,
    WAIT,
    STEP,
    SAMPLE,
    DONE
  } state_t;

  localparam int unsigned VREF_W      = 9;
  localparam int unsigned VREG_W      = 9;
  localparam int unsigned OUT_W       = 7;
  localparam int unsigned MRST_CYCLES = 2;

  // 8-bit unsigned |a-b|; the output codes are only 7 bits wide, so this cannot overflow
  function automatic logic [7:0] abs_diff(input logic [OUT_W-1:0] a,
                                          input logic [OUT_W-1:0] b);
    logic [7:0] ea;
    logic [7:0] eb;
    ea = 8'(a);
    eb = 8'(b);
    return (ea >= eb) ? (ea - eb) : (eb - ea);
  endfunction

endpackage

// File: rtl/eval_settle_detector.sv
// Tracks consecutive in-tolerance samples of the model output.
// It flags the sample on which the run of stable samples reaches SETTLE_STEPS.
module eval_settle_detector
  import eval_seq_pkg::*;
#(
  parameter int unsigned SETTLE_STEPS = 8,
  parameter int unsigned TOL          = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             sample,
  input  logic [OUT_W-1:0] sample_code,
  output logic             settled
);

  localparam int unsigned SC_W = $clog2(SETTLE_STEPS + 1);

  logic [OUT_W-1:0] prev;
  logic             prev_valid;
  logic [SC_W-1:0]  stable_cnt;
  logic [SC_W-1:0]  stable_nxt;
  logic [7:0]       diff;

  // The first sample after a clear has no predecessor, so it never counts as stable
  always_comb begin
    diff       = abs_diff(sample_code, prev);
    stable_nxt = '0;
    if (prev_valid && (32'(diff) <= TOL)) begin
      stable_nxt = stable_cnt + SC_W'(1);
    end
    settled = sample && (stable_nxt == SC_W'(SETTLE_STEPS));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      stable_cnt <= '0;
    end else if (clear) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      stable_cnt <= '0;
    end else if (sample) begin
      prev       <= sample_code;
      prev_valid <= 1'b1;
      stable_cnt <= stable_nxt;
    end
  end

endmodule

// File: rtl/eval_settle_sequencer.sv
// Sequences one evaluate-model operating point: model reset, paced steps,
// settle/timeout detection, then a held response over valid/ready.
module eval_settle_sequencer
  import eval_seq_pkg::*;
#(
  parameter int unsigned STEP_DIV     = 4,
  parameter int unsigned SETTLE_STEPS = 8,
  parameter int unsigned TOL          = 1,
  parameter int unsigned MAX_STEPS    = 1024,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [VREF_W-1:0] req_vref,
  input  logic [VREG_W-1:0] req_vreg,
  output logic [VREF_W-1:0] model_vref,
  output logic [VREG_W-1:0] model_vreg,
  output logic              model_reset,
  output logic              model_step,
  input  logic [OUT_W-1:0]  model_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [OUT_W-1:0]  rsp_out,
  output logic [CNT_W-1:0]  rsp_steps,
  output logic              rsp_timeout,
  output logic              busy
);

  localparam int unsigned DIV_W  = $clog2(STEP_DIV + 1);
  localparam int unsigned MRST_W = $clog2(MRST_CYCLES + 1);

  if ((STEP_DIV < 1) || (SETTLE_STEPS < 1) || (MAX_STEPS < SETTLE_STEPS + 1) ||
      ((64'(MAX_STEPS) >> CNT_W) != 64'd0)) begin : g_bad_params
    $error("eval_settle_sequencer: illegal STEP_DIV/SETTLE_STEPS/MAX_STEPS/CNT_W combination");
  end

  state_t            state;
  state_t            state_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic [MRST_W-1:0] mrst_cnt;
  logic [CNT_W-1:0]  step_cnt;
  logic              det_clear;
  logic              det_sample;
  logic              settled;
  logic              at_max;

  assign at_max = (step_cnt == CNT_W'(MAX_STEPS));

  eval_settle_detector #(
    .SETTLE_STEPS(SETTLE_STEPS),
    .TOL         (TOL)
  ) u_detector (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (det_clear),
    .sample     (det_sample),
    .sample_code(model_out),
    .settled    (settled)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    model_reset = 1'b0;
    model_step  = 1'b0;
    rsp_valid   = 1'b0;
    busy        = 1'b1;
    det_clear   = 1'b0;
    det_sample  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready   = 1'b1;
        model_reset = 1'b1;
        busy        = 1'b0;
        if (req_valid) begin
          det_clear = 1'b1;
          state_nxt = MRST;
        end
      end
      MRST: begin
        model_reset = 1'b1;
        if (mrst_cnt == MRST_W'(MRST_CYCLES - 1)) state_nxt = WAIT;
      end
      WAIT: begin
        if (div_cnt == DIV_W'(STEP_DIV - 1)) state_nxt = STEP;
      end
      STEP: begin
        model_step = 1'b1;
        state_nxt  = SAMPLE;
      end
      SAMPLE: begin
        det_sample = 1'b1;
        // Settling is checked first so it wins when it lands on the last budgeted step
        if (settled || at_max) state_nxt = DONE;
        else                   state_nxt = WAIT;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_vref  <= '0;
      model_vreg  <= '0;
      div_cnt     <= '0;
      mrst_cnt    <= '0;
      step_cnt    <= '0;
      rsp_out     <= '0;
      rsp_steps   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      div_cnt  <= (state == WAIT) ? (div_cnt + DIV_W'(1)) : '0;
      mrst_cnt <= (state == MRST) ? (mrst_cnt + MRST_W'(1)) : '0;
      if ((state == IDLE) && req_valid) begin
        model_vref <= req_vref;
        model_vreg <= req_vreg;
        step_cnt   <= '0;
      end
      if (state == STEP) begin
        step_cnt <= step_cnt + CNT_W'(1);
      end
      if (state == SAMPLE) begin
        rsp_out     <= model_out;
        rsp_steps   <= step_cnt;
        rsp_timeout <= !settled && at_max;
      end
    end
  end

endmodule

// File: tb/tb_eval_settle_sequencer.sv
// Bench for eval_settle_sequencer: three parameterisations driven by a
// behavioural step-clocked model, with responses checked against a scoreboard.
module tb_eval_settle_sequencer;

  localparam int NI     = 3;
  localparam int PERIOD = 6;

  typedef struct {
    logic [6:0]  out;
    logic [15:0] steps;
    logic        to;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [8:0]  req_vref;
  logic [8:0]  req_vreg;
  logic        req_valid   [NI];
  logic        rsp_ready   [NI];
  logic        req_ready   [NI];
  logic [8:0]  model_vref  [NI];
  logic [8:0]  model_vreg  [NI];
  logic        model_reset [NI];
  logic        model_step  [NI];
  logic [6:0]  model_out   [NI];
  logic        rsp_valid   [NI];
  logic [6:0]  rsp_out     [NI];
  logic [15:0] rsp_steps   [NI];
  logic        rsp_timeout [NI];
  logic        busy        [NI];

  int mode [NI];
  int kstep[NI];

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  eval_settle_sequencer u_def (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_vref(req_vref), .req_vreg(req_vreg), .model_vref(model_vref[0]),
    .model_vreg(model_vreg[0]), .model_reset(model_reset[0]), .model_step(model_step[0]),
    .model_out(model_out[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_out(rsp_out[0]), .rsp_steps(rsp_steps[0]), .rsp_timeout(rsp_timeout[0]),
    .busy(busy[0]));

  eval_settle_sequencer #(.TOL(0), .MAX_STEPS(20)) u_max20 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_vref(req_vref), .req_vreg(req_vreg), .model_vref(model_vref[1]),
    .model_vreg(model_vreg[1]), .model_reset(model_reset[1]), .model_step(model_step[1]),
    .model_out(model_out[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_out(rsp_out[1]), .rsp_steps(rsp_steps[1]), .rsp_timeout(rsp_timeout[1]),
    .busy(busy[1]));

  eval_settle_sequencer #(.MAX_STEPS(9)) u_max9 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_vref(req_vref), .req_vreg(req_vreg), .model_vref(model_vref[2]),
    .model_vreg(model_vreg[2]), .model_reset(model_reset[2]), .model_step(model_step[2]),
    .model_out(model_out[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_out(rsp_out[2]), .rsp_steps(rsp_steps[2]), .rsp_timeout(rsp_timeout[2]),
    .busy(busy[2]));

  // Output after the n-th step (1-based) for each stimulus pattern
  function automatic logic [6:0] model_fn(input int m, input int n);
    case (m)
      1:       return (n <= 11) ? 7'(10 * (n - 1)) : 7'd100;
      2:       return (n % 2 == 1) ? 7'd40 : 7'd50;
      3:       return (n % 2 == 1) ? 7'd60 : 7'd61;
      default: return 7'd42;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (model_reset[g]) begin
        kstep[g]     <= 0;
        model_out[g] <= '0;
      end else if (model_step[g]) begin
        kstep[g]     <= kstep[g] + 1;
        model_out[g] <= model_fn(mode[g], kstep[g] + 1);
      end
    end
  end

  task automatic start_req(input int g, input logic [8:0] vr, input logic [8:0] vg);
    req_vref     = vr;
    req_vreg     = vg;
    req_valid[g] = 1'b1;
    @(posedge clk); #1;
    req_valid[g] = 1'b0;
  endtask

  // Cycles from the accept edge until rsp_valid, plus step-pulse count and spacing errors
  task automatic wait_rsp(input int g, input int budget, output int lat,
                          output int npulse, output int gap_err);
    int last;
    lat     = -1;
    npulse  = 0;
    gap_err = 0;
    last    = 0;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk); #1;
      if (model_step[g]) begin
        if (n - last != PERIOD) gap_err++;
        last = n;
        npulse++;
      end
      if (rsp_valid[g]) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic finish_rsp(input int g);
    rsp_ready[g] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[g] = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    for (int g = 0; g < NI; g++) begin
      req_valid[g] = 1'b0;
      rsp_ready[g] = 1'b0;
      mode[g]      = 0;
    end
    req_vref = '0;
    req_vreg = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      checks++;
      if (model_reset[g] !== 1'b1 || model_step[g] !== 1'b0) begin
        errors++; $display("FAIL reset_model[%0d] reset=%b step=%b expected 1 0", g, model_reset[g], model_step[g]);
      end
      checks++;
      if (req_ready[g] !== 1'b1 || busy[g] !== 1'b0 || rsp_valid[g] !== 1'b0) begin
        errors++; $display("FAIL reset_hs[%0d] ready=%b busy=%b valid=%b expected 1 0 0", g, req_ready[g], busy[g], rsp_valid[g]);
      end
      checks++;
      if (rsp_out[g] !== 7'd0 || rsp_steps[g] !== 16'd0 || rsp_timeout[g] !== 1'b0 || model_vref[g] !== 9'd0) begin
        errors++; $display("FAIL reset_regs[%0d] out=%0d steps=%0d to=%b vref=%0d expected zeros", g, rsp_out[g], rsp_steps[g], rsp_timeout[g], model_vref[g]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_default;
    rsp_t e;
    int lat, np, ge;
    mode[0] = 0;
    sb.push_back('{out: 7'd42, steps: 16'd9, to: 1'b0});
    start_req(0, 9'd200, 9'd300);
    checks++;
    if (busy[0] !== 1'b1 || req_ready[0] !== 1'b0) begin
      errors++; $display("FAIL default_busy busy=%b ready=%b expected 1 0", busy[0], req_ready[0]);
    end
    checks++;
    if (model_vref[0] !== 9'd200 || model_vreg[0] !== 9'd300) begin
      errors++; $display("FAIL default_latch vref=%0d vreg=%0d expected 200 300", model_vref[0], model_vreg[0]);
    end
    wait_rsp(0, 300, lat, np, ge);
    checks++;
    if (lat != 56) begin errors++; $display("FAIL default_latency got %0d expected 56", lat); end
    checks++;
    if (np != 9 || ge != 0) begin
      errors++; $display("FAIL default_pulses count=%0d gap_errors=%0d expected 9 0", np, ge);
    end
    e = sb.pop_front();
    checks++;
    if (rsp_out[0] !== e.out || rsp_steps[0] !== e.steps || rsp_timeout[0] !== e.to) begin
      errors++; $display("FAIL default_rsp out=%0d steps=%0d to=%b expected %0d %0d %b", rsp_out[0], rsp_steps[0], rsp_timeout[0], e.out, e.steps, e.to);
    end
    finish_rsp(0);
    checks++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      errors++; $display("FAIL default_release valid=%b ready=%b expected 0 1", rsp_valid[0], req_ready[0]);
    end
  endtask

  // Runs one request on instance g and checks latency and the scoreboard entry
  task automatic test_scenario(input string name, input int g, input int m,
                               input int exp_lat, input rsp_t exp);
    rsp_t e;
    int lat, np, ge;
    mode[g] = m;
    sb.push_back(exp);
    start_req(g, 9'd17, 9'd33);
    wait_rsp(g, 400, lat, np, ge);
    checks++;
    if (lat != exp_lat) begin errors++; $display("FAIL %s_latency got %0d expected %0d", name, lat, exp_lat); end
    e = sb.pop_front();
    checks++;
    if (rsp_out[g] !== e.out || rsp_steps[g] !== e.steps || rsp_timeout[g] !== e.to) begin
      errors++; $display("FAIL %s_rsp out=%0d steps=%0d to=%b expected %0d %0d %b", name, rsp_out[g], rsp_steps[g], rsp_timeout[g], e.out, e.steps, e.to);
    end
    finish_rsp(g);
  endtask

  task automatic test_backpressure;
    rsp_t e;
    int lat, np, ge;
    mode[0] = 0;
    sb.push_back('{out: 7'd42, steps: 16'd9, to: 1'b0});
    start_req(0, 9'd5, 9'd6);
    wait_rsp(0, 300, lat, np, ge);
    checks++;
    if (lat != 56) begin errors++; $display("FAIL bp_latency got %0d expected 56", lat); end
    e = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        req_vref     = 9'd77;
        req_valid[0] = 1'b1;
      end else begin
        req_valid[0] = 1'b0;
      end
      @(posedge clk); #1;
      checks++;
      if (rsp_valid[0] !== 1'b1 || req_ready[0] !== 1'b0 || rsp_out[0] !== e.out ||
          rsp_steps[0] !== e.steps || rsp_timeout[0] !== e.to || model_vref[0] !== 9'd5) begin
        errors++; $display("FAIL bp_hold[%0d] valid=%b ready=%b out=%0d steps=%0d to=%b vref=%0d expected 1 0 %0d %0d %b 5", i, rsp_valid[0], req_ready[0], rsp_out[0], rsp_steps[0], rsp_timeout[0], model_vref[0], e.out, e.steps, e.to);
      end
    end
    req_valid[0] = 1'b0;
    finish_rsp(0);
    checks++;
    if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL bp_release ready=%b valid=%b busy=%b expected 1 0 0", req_ready[0], rsp_valid[0], busy[0]);
    end
  endtask

  task automatic test_reset_mid_wait;
    rsp_t e;
    int lat, np, ge;
    mode[0] = 0;
    start_req(0, 9'd11, 9'd22);
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (model_reset[0] !== 1'b0 || busy[0] !== 1'b1) begin
      errors++; $display("FAIL midreset_pre model_reset=%b busy=%b expected 0 1", model_reset[0], busy[0]);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (model_reset[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL midreset_abort model_reset=%b valid=%b busy=%b expected 1 0 0", model_reset[0], rsp_valid[0], busy[0]);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      errors++; $display("FAIL midreset_idle valid=%b ready=%b expected 0 1", rsp_valid[0], req_ready[0]);
    end
    sb.push_back('{out: 7'd42, steps: 16'd9, to: 1'b0});
    start_req(0, 9'd1, 9'd2);
    wait_rsp(0, 300, lat, np, ge);
    checks++;
    if (lat != 56 || np != 9) begin
      errors++; $display("FAIL midreset_rerun latency=%0d pulses=%0d expected 56 9", lat, np);
    end
    e = sb.pop_front();
    checks++;
    if (rsp_out[0] !== e.out || rsp_steps[0] !== e.steps || rsp_timeout[0] !== e.to) begin
      errors++; $display("FAIL midreset_rsp out=%0d steps=%0d to=%b expected %0d %0d %b", rsp_out[0], rsp_steps[0], rsp_timeout[0], e.out, e.steps, e.to);
    end
    finish_rsp(0);
  endtask

  initial begin
    test_reset();
    test_default();
    test_scenario("ramp",        0, 1, 2 + 19 * PERIOD, '{out: 7'd100, steps: 16'd19, to: 1'b0});
    test_scenario("timeout",     1, 2, 2 + 20 * PERIOD, '{out: 7'd50,  steps: 16'd20, to: 1'b1});
    test_scenario("tol1_edge",   0, 3, 2 + 9 * PERIOD,  '{out: 7'd60,  steps: 16'd9,  to: 1'b0});
    test_scenario("tol0_edge",   1, 3, 2 + 20 * PERIOD, '{out: 7'd61,  steps: 16'd20, to: 1'b1});
    test_scenario("settle_wins", 2, 0, 2 + 9 * PERIOD,  '{out: 7'd42,  steps: 16'd9,  to: 1'b0});
    test_backpressure();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
